// File: rtl/async_receiver.sv
// 8N1 UART receiver: 16x oversampling, 7/8/9 majority vote per bit,
// false-start rejection, stop-bit framing check and break handling.
module async_receiver #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DIV        = (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_frame_error,
   output logic       RxD_busy
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

   state_t          state;
   logic [1:0]      sync;
   logic            rx_prev;
   logic [DW-1:0]   div_cnt;
   logic [SW-1:0]   sample_cnt;
   logic [2:0]      bit_idx;
   logic [1:0]      votes;
   logic [7:0]      shreg;
   logic            rxs, tick, fall, maj, at7, at8, at9, at15;

   assign rxs  = sync[1];
   assign tick = (div_cnt == DW'(DIV - 1));
   assign fall = rx_prev & ~rxs;
   // third vote is the live sample at the cnt-9 tick
   assign maj  = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
   assign at7  = tick && (sample_cnt == SW'(7));
   assign at8  = tick && (sample_cnt == SW'(8));
   assign at9  = tick && (sample_cnt == SW'(9));
   assign at15 = tick && (sample_cnt == SW'(15));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         sync            <= 2'b11;
         rx_prev         <= 1'b1;
         div_cnt         <= '0;
         sample_cnt      <= '0;
         bit_idx         <= '0;
         votes           <= '0;
         shreg           <= '0;
         RxD_data        <= '0;
         RxD_data_ready  <= 1'b0;
         RxD_frame_error <= 1'b0;
         RxD_busy        <= 1'b0;
      end else begin
         sync            <= {sync[0], RxD};
         rx_prev         <= rxs;
         RxD_data_ready  <= 1'b0;
         RxD_frame_error <= 1'b0;
         if (tick) begin
            div_cnt    <= '0;
            sample_cnt <= sample_cnt + SW'(1);
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
         if (at7) votes[0] <= rxs;
         if (at8) votes[1] <= rxs;

         case (state)
            S_IDLE:
               if (fall) begin
                  state      <= S_START;
                  RxD_busy   <= 1'b1;
                  div_cnt    <= '0;
                  sample_cnt <= '0;
               end
            S_START:
               if (at9 && maj) begin
                  state    <= S_IDLE;
                  RxD_busy <= 1'b0;
               end else if (at15) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
               end
            S_DATA: begin
               if (at9) shreg <= {maj, shreg[7:1]};
               if (at15) begin
                  if (bit_idx == 3'd7) state <= S_STOP;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            S_STOP:
               if (at9) begin
                  if (maj) begin
                     RxD_data       <= shreg;
                     RxD_data_ready <= 1'b1;
                     // a start edge landing on the vote cycle is taken directly
                     if (fall) begin
                        state      <= S_START;
                        div_cnt    <= '0;
                        sample_cnt <= '0;
                     end else begin
                        state    <= S_IDLE;
                        RxD_busy <= 1'b0;
                     end
                  end else begin
                     RxD_frame_error <= 1'b1;
                     state           <= S_BRK;
                  end
               end
            S_BRK:
               if (rxs) begin
                  state    <= S_IDLE;
                  RxD_busy <= 1'b0;
               end
            default: begin
               state    <= S_IDLE;
               RxD_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_async_receiver.sv
// Scoreboard bench for async_receiver: stimulus pushes expected events,
// a negedge monitor pops and compares on every data_ready/frame_error pulse.
module tb_async_receiver;
   localparam int CLK_FREQ = 12_800_000;
   localparam int BAUD     = 100_000;
   localparam int BIT      = 128;   // DIV = 8, 16 ticks per bit

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       RxD   = 1'b1;
   logic [7:0] RxD_data;
   logic       RxD_data_ready, RxD_frame_error, RxD_busy;

   async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .RxD             (RxD),
      .RxD_data        (RxD_data),
      .RxD_data_ready  (RxD_data_ready),
      .RxD_frame_error (RxD_frame_error),
      .RxD_busy        (RxD_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic err; logic [7:0] data; } exp_t;
   exp_t       exp_q[$];
   exp_t       mon_e;
   int         tests = 0, fails = 0;
   logic [7:0] model_data = 8'h00;
   int         cyc = 0, lat_start = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // start bit, 8 data bits LSB first, stop bit; optional short inversion
   // window in one data bit that overlaps only the first vote sample
   task automatic send(input logic [7:0] b, input int blen, input logic stop_bit,
                       input int noise_bit);
      RxD = 1'b0; wait_clk(blen);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         if (i == noise_bit) begin
            wait_clk(61); RxD = ~b[i];
            wait_clk(8);  RxD = b[i];
            wait_clk(blen - 69);
         end else begin
            wait_clk(blen);
         end
      end
      RxD = stop_bit; wait_clk(blen);
   endtask

   task automatic good(input logic [7:0] b, input int blen, input int noise_bit);
      exp_q.push_back(exp_t'({1'b0, b}));
      send(b, blen, 1'b1, noise_bit);
   endtask

   always @(negedge clk) begin
      if (rst_n && (RxD_data_ready || RxD_frame_error)) begin
         check("exclusive_pulse", int'(RxD_data_ready & RxD_frame_error), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_event", int'({RxD_frame_error, RxD_data_ready}), 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_is_error", int'(RxD_frame_error), int'(mon_e.err));
            if (!mon_e.err) model_data = mon_e.data;
            check("rx_data", int'(RxD_data), int'(model_data));
            if (lat_start >= 0) begin
               check("latency_window",
                     int'((cyc - lat_start >= 1214) && (cyc - lat_start <= 1238)), 1);
               lat_start = -1;
            end
         end
      end
   end

   initial begin
      wait_clk(5);
      check("reset_data",  int'(RxD_data), 0);
      check("reset_ready", int'(RxD_data_ready), 0);
      check("reset_ferr",  int'(RxD_frame_error), 0);
      check("reset_busy",  int'(RxD_busy), 0);
      rst_n = 1'b1;
      wait_clk(2*BIT);

      // single frame with latency measurement
      exp_q.push_back(exp_t'({1'b0, 8'h2F}));
      lat_start = cyc;
      send(8'h2F, BIT, 1'b1, -1);
      wait_clk(BIT);
      check("busy_after_2f", int'(RxD_busy), 0);

      // back-to-back, next start right after stop
      good(8'h2F, BIT, -1);
      good(8'hAA, BIT, -1);
      wait_clk(2*BIT);

      // short glitch is rejected as a false start
      RxD = 1'b0; wait_clk(10);
      check("busy_in_glitch", int'(RxD_busy), 1);
      wait_clk(10); RxD = 1'b1;
      wait_clk(2*BIT);
      check("busy_after_glitch", int'(RxD_busy), 0);
      good(8'h55, BIT, -1);
      wait_clk(BIT);

      // single-sample noise in bit 3 is voted out
      good(8'hA5, BIT, 3);
      wait_clk(BIT);

      // bad stop bit, line held low 3 bit times, then recovery
      exp_q.push_back(exp_t'({1'b1, 8'h00}));
      send(8'h3C, BIT, 1'b0, -1);
      wait_clk(2*BIT);
      check("busy_in_break", int'(RxD_busy), 1);
      RxD = 1'b1;
      wait_clk(2*BIT);
      check("busy_after_break", int'(RxD_busy), 0);
      good(8'hC3, BIT, -1);
      wait_clk(BIT);

      // reset during bit 4 of 8'hF0 (line high there)
      RxD = 1'b0; wait_clk(BIT);
      for (int i = 0; i < 4; i++) wait_clk(BIT);
      RxD = 1'b1; wait_clk(40);
      check("busy_mid_frame", int'(RxD_busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_data",  int'(RxD_data), 0);
      check("midrst_ready", int'(RxD_data_ready), 0);
      check("midrst_ferr",  int'(RxD_frame_error), 0);
      check("midrst_busy",  int'(RxD_busy), 0);
      model_data = 8'h00;
      wait_clk(10);
      rst_n = 1'b1;
      wait_clk(5*BIT);
      check("busy_after_rst", int'(RxD_busy), 0);
      good(8'h0F, BIT, -1);
      wait_clk(BIT);

      // roughly +/-3% baud mismatch
      good(8'h96, 124, -1);
      wait_clk(2*BIT);
      good(8'h69, 132, -1);

      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) wait_clk(1);
      check("queue_drained", exp_q.size(), 0);
      wait_clk(BIT);
      check("busy_final", int'(RxD_busy), 0);
      check("final_data", int'(RxD_data), 8'h69);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/async_receiver.md
Name: async_receiver

Overview:
- UART receive stage: consumes the serial line produced by the transmitter (TxD → RxD loopback in system and benches).
- Recovers 8N1 frames, LSB first, and presents each byte with a one-cycle valid strobe to downstream logic.
- Uses 16x oversampling, a 3-sample majority vote per bit, false-start rejection and stop-bit framing check.
- Same clock domain and baud settings as the transmitter.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line bit rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; fixed 16, and the vote positions below assume it
DIV, (CLK_FREQ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), derived clocks per sample tick (326 at defaults)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
RxD  input  1  serial line, idle high, asynchronous to clk
RxD_data  output  8  last correctly framed byte, held until the next good frame
RxD_data_ready  output  1  one-cycle pulse when RxD_data updates
RxD_frame_error  output  1  one-cycle pulse when the stop bit samples 0
RxD_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: one clock, asynchronous and active-low; rst_n low forces the following immediately:
  - state IDLE; synchroniser flops = 1; counters = 0.
  - RxD_data = 8'h00; RxD_data_ready, RxD_frame_error and RxD_busy = 0.
  - Reset asserted mid-frame discards the partial byte.
  - After release, the receiver waits for a fresh falling edge; it does not resynchronise into the middle of a frame.
- Synchroniser: 2 flops on RxD, reset value 1. All logic below uses the synchronised value rxs. Input-to-rxs latency is 2 clocks.
- Tick generator: divider counts 0..DIV-1 and emits tick on DIV-1. It is cleared in the same cycle a start edge is accepted, so bit phase aligns to the edge. sample_cnt (4 bits) advances on each tick and wraps 15→0.
- States:
  - IDLE: rxs falling edge (prev 1, now 0) → START. Clear divider and sample_cnt.
  - START:
    - Capture rxs on ticks with sample_cnt 7, 8 and 9.
    - At the tick where sample_cnt = 9, compute the majority.
    - Majority 1 → false start: return to IDLE, no output pulses.
    - Majority 0 → continue; on the sample_cnt 15 tick go to DATA, bit_idx = 0.
  - DATA:
    - Same 7/8/9 vote per bit; voted bit shifts into the shift register MSB side (LSB received first).
    - On the sample_cnt 15 tick: bit_idx increments; after bit_idx 7 go to STOP.
  - STOP, vote at sample_cnt 9:
    - Majority 1: RxD_data <= shift register and RxD_data_ready = 1 for exactly one clk; → IDLE immediately. This allows back-to-back frames whose next start edge arrives in the second half of the stop bit.
    - Majority 0: RxD_frame_error = 1 for one clk; RxD_data unchanged; → BREAK.
  - BREAK: wait until rxs = 1, then → IDLE. A held-low line (break) therefore produces exactly one frame_error and no spurious frames.
- Latency: RxD_data_ready rises 9.5625 bit times (±1 tick) + 2–3 clk after the start-bit falling edge at the RxD pin.
- Simultaneous events:
  - data_ready and frame_error are never high together.
  - A falling edge seen in the same cycle as the STOP→IDLE transition is not lost: IDLE edge detection uses the registered previous rxs, which is updated every cycle in every state.
- Overrun: there is no handshake. Downstream must consume RxD_data before the next data_ready; a new good frame overwrites it.
- Tolerance: correct reception for a baud mismatch of at least ±3% versus the transmitter.

Test Plan:
- Loopback from async_transmitter (defaults, 50 MHz), send 8'h2F → exactly one RxD_data_ready pulse, about 990 µs after the start edge, with RxD_data = 8'h2F; RxD_frame_error never pulses; RxD_busy low afterwards.
- Back-to-back 8'h2F then 8'hAA with minimum gap (next start immediately after stop) → two data_ready pulses; RxD_data = 8'h2F, then 8'hAA; no frame_error.
- Glitch: RxD low for 20 µs (< half bit, ~52 µs), then high → busy pulses high then returns to IDLE; no data_ready, no frame_error; a following 8'h55 frame is received correctly.
- Noise: during the data phase of 8'hA5, invert RxD for 6 µs (covers only one of the 3 vote samples) in bit 3 → RxD_data = 8'hA5.
- Framing: drive a frame of 8'h3C with stop bit 0, hold low 3 bit times, then high, then send a valid 8'hC3 → one frame_error pulse; RxD_data keeps its prior value; then data_ready with RxD_data = 8'hC3.
- Reset mid-frame: assert rst_n low during bit 4 of 8'hF0 for 100 ns → outputs return to reset values immediately; no pulses for the aborted frame; the next clean 8'h0F is received correctly.
